// File: rtl/mc_muldiv_pkg.sv
// Shared op codes and FSM encoding for the multiply/divide unit.
package mc_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // Ops that run the iterative datapath.
  function automatic logic op_is_calc(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_move(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation on two WIDTH values and one
// 2*WIDTH value. Gives magnitudes at operand latch and applies the
// result signs at fix-up.
module md_sign_fix
  import mc_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   n0_in,
  input  logic               n0_neg,
  output logic [WIDTH-1:0]   n0_out,
  input  logic [WIDTH-1:0]   n1_in,
  input  logic               n1_neg,
  output logic [WIDTH-1:0]   n1_out,
  input  logic [2*WIDTH-1:0] w_in,
  input  logic               w_neg,
  output logic [2*WIDTH-1:0] w_out
);

  // Negate each value when its flag is set, pass through otherwise.
  always_comb begin
    n0_out = n0_neg ? -n0_in : n0_in;
    n1_out = n1_neg ? -n1_in : n1_in;
    w_out  = w_neg  ? -w_in  : w_in;
  end

endmodule

// File: rtl/mc_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers. Shift-add
// multiply and restoring divide, one bit per cycle, on magnitudes with
// a final sign fix-up state.
module mc_muldiv
  import mc_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  md_state_t          state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div, zdiv, neg_q, neg_r;

  logic               launch, mt_wr, step, fix_wr;
  logic               is_sgn;

  logic [WIDTH-1:0]   n0_in, n1_in, sf_n0, sf_n1;
  logic               n0_neg, n1_neg;
  logic [2*WIDTH-1:0] sf_w;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_r, div_diff;
  logic               qbit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state; flush overrides everything, including a launch in IDLE.
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start && op_is_calc(op)) state_nx = ST_CALC;
        ST_CALC: if (cnt == '0) state_nx = ST_FIX;
        ST_FIX:  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Control decode from state; busy has no path from start.
  always_comb begin
    busy   = (state != ST_IDLE);
    launch = (state == ST_IDLE) && start && !flush && op_is_calc(op);
    mt_wr  = (state == ST_IDLE) && start && !flush && op_is_move(op);
    step   = (state == ST_CALC) && !flush;
    fix_wr = (state == ST_FIX)  && !flush;
  end

  // The sign-fix block is shared: raw operands while idle, the
  // accumulator halves and full product while calculating/fixing.
  always_comb begin
    is_sgn = op_is_signed(op);
    if (state == ST_IDLE) begin
      n0_in  = a;
      n0_neg = is_sgn & a[WIDTH-1];
      n1_in  = b;
      n1_neg = is_sgn & b[WIDTH-1];
    end else begin
      n0_in  = acc[WIDTH-1:0];
      n0_neg = neg_q;
      n1_in  = acc[2*WIDTH-1:WIDTH];
      n1_neg = neg_r;
    end
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .n0_in  (n0_in),
    .n0_neg (n0_neg),
    .n0_out (sf_n0),
    .n1_in  (n1_in),
    .n1_neg (n1_neg),
    .n1_out (sf_n1),
    .w_in   (acc),
    .w_neg  (neg_q),
    .w_out  (sf_w)
  );

  // One iteration step of each algorithm on the accumulator.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_r - {1'b0, opd};
    qbit     = ~div_diff[WIDTH];
  end

  // Operand latch and iteration: acc = {upper, lower}; multiply shifts
  // right with the multiplier in the lower half, divide shifts left
  // with the remainder in the upper half and quotient bits in the lower.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opd    <= '0;
      a_raw  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      zdiv   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (launch) begin
      is_div <= op_is_div(op);
      zdiv   <= op_is_div(op) && (b == '0);
      a_raw  <= a;
      neg_q  <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r  <= is_sgn & a[WIDTH-1];
      cnt    <= CW'(WIDTH - 1);
      if (op_is_div(op)) begin
        acc <= {{WIDTH{1'b0}}, sf_n0};
        opd <= sf_n1;
      end else begin
        acc <= {{WIDTH{1'b0}}, sf_n1};
        opd <= sf_n0;
      end
    end else if (step) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (is_div)
        acc <= {(qbit ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0]), acc[WIDTH-2:0], qbit};
      else
        acc <= {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Architectural HI/LO plus registered done/dbz pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      done <= fix_wr | mt_wr;
      dbz  <= fix_wr & zdiv;
      if (mt_wr) begin
        if (op == MD_MTHI) hi <= a;
        else               lo <= a;
      end else if (fix_wr) begin
        if (!is_div) begin
          {hi, lo} <= sf_w;
        end else if (zdiv) begin
          hi <= a_raw;
          lo <= '1;
        end else begin
          hi <= sf_n1;
          lo <= sf_n0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mc_muldiv.sv
// Scoreboard bench for mc_muldiv: directed 32-bit cases plus a random
// 8-bit sweep against a behavioural reference.
module tb_mc_muldiv;
  import mc_muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, dbz;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dbz8;

  mc_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  mc_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int unsigned lat;
    int unsigned issue;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t sb8[$];
  int unsigned cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  logic [7:0] m_hi8 = '0, m_lo8 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // 32-bit result monitor.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
        chk({e.tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
        chk({e.tag, "_dbz"}, {63'd0, dbz}, {63'd0, e.dbz});
        chk({e.tag, "_lat"}, 64'(cyc - e.issue + 1), 64'(e.lat));
      end
    end
  end

  // 8-bit result monitor.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done8) begin
      if (sb8.size() == 0) begin
        chk("spurious_done8", 64'd1, 64'd0);
      end else begin
        e = sb8.pop_front();
        chk({e.tag, "_hi"}, {56'd0, hi8}, {32'd0, e.hi});
        chk({e.tag, "_lo"}, {56'd0, lo8}, {32'd0, e.lo});
        chk({e.tag, "_dbz"}, {63'd0, dbz8}, {63'd0, e.dbz});
        chk({e.tag, "_lat"}, 64'(cyc - e.issue + 1), 64'(e.lat));
      end
    end
  end

  // Called at a negedge: drive start for one cycle, optionally expecting a result.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input string tag, input logic push, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edbz, input int unsigned lat);
    exp_t e;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz; e.lat = lat; e.issue = cyc + 1; e.tag = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Advance to the negedge inside the next done cycle.
  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic exp_t ref8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] chi, input logic [7:0] clo);
    exp_t e;
    logic [15:0] p;
    logic signed [7:0] sx, sy, sq, sr;
    sx = x; sy = y;
    e.hi = {24'd0, chi}; e.lo = {24'd0, clo}; e.dbz = 1'b0; e.lat = 10; e.issue = 0; e.tag = "rnd";
    case (o)
      MD_MULT: begin
        p = $signed(x) * $signed(y);
        e.hi = {24'd0, p[15:8]}; e.lo = {24'd0, p[7:0]};
      end
      MD_MULTU: begin
        p = {8'd0, x} * {8'd0, y};
        e.hi = {24'd0, p[15:8]}; e.lo = {24'd0, p[7:0]};
      end
      MD_DIV, MD_DIVU: begin
        if (y == 8'd0) begin
          e.hi = {24'd0, x}; e.lo = 32'h0000_00FF; e.dbz = 1'b1;
        end else if (o == MD_DIV && x == 8'h80 && y == 8'hFF) begin
          e.hi = 32'd0; e.lo = 32'h0000_0080;
        end else if (o == MD_DIV) begin
          sq = sx / sy; sr = sx % sy;
          e.hi = {24'd0, sr}; e.lo = {24'd0, sq};
        end else begin
          e.hi = {24'd0, x % y}; e.lo = {24'd0, x / y};
        end
      end
      MD_MTHI: begin e.hi = {24'd0, x}; e.lat = 1; end
      MD_MTLO: begin e.lo = {24'd0, x}; e.lat = 1; end
      default: ;
    endcase
    return e;
  endfunction

  initial begin
    exp_t e;
    logic [2:0] ro;
    logic [7:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #2;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz", {63'd0, dbz}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-range unsigned multiply with latency check.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1, 32'hFFFF_FFFE, 32'h0000_0001, 0, 34);
    chk("multu_busy", {63'd0, busy}, 64'd1);
    wait_idle("multu_max");

    // Back-to-back chain: each start lands in the previous done cycle.
    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 34);
    wait_done("mult_neg");
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 34);
    wait_done("div_neg");
    issue(MD_DIVU, 32'd7, 32'd0, "divu_dbz", 1, 32'h0000_0007, 32'hFFFF_FFFF, 1, 34);
    wait_done("divu_dbz");
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1, 32'd0, 32'h8000_0000, 0, 34);
    wait_idle("div_ovf");

    // MTHI: one-cycle done, busy stays low.
    issue(MD_MTHI, 32'h0000_1234, 32'd0, "mthi", 1, 32'h0000_1234, 32'h8000_0000, 0, 1);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    wait_idle("mthi");

    // Restart attempt in cycle 5 must be ignored.
    issue(MD_MULTU, 32'h0001_0000, 32'h0000_0010, "multu_ign", 1, 32'd0, 32'h0010_0000, 0, 34);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle("multu_ign");

    // Flush in cycle 10: no done, registers retained.
    issue(MD_MULT, 32'd2, 32'd3, "flush", 0, 32'd0, 32'd0, 0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_hi", {32'd0, hi}, 64'd0);
    chk("flush_lo", {32'd0, lo}, 64'h0010_0000);

    // Flush with start in IDLE drops the start.
    start = 1'b1; flush = 1'b1; op = MD_MTLO; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("flush_start_lo", {32'd0, lo}, 64'h0010_0000);

    // Reset mid-divide.
    issue(MD_DIV, 32'd100, 32'd7, "div_rst", 1, 32'd2, 32'd14, 0, 34);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_hi", {32'd0, hi}, 64'd0);
    chk("arst_lo", {32'd0, lo}, 64'h0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Random 8-bit sweep against the reference.
    for (int n = 0; n < 80; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 8'h00;
        1: rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      if (ro <= MD_MTLO) begin
        e = ref8(ro, ra, rb, m_hi8, m_lo8);
        e.issue = cyc + 1;
        sb8.push_back(e);
        m_hi8 = e.hi[7:0];
        m_lo8 = e.lo[7:0];
      end
      start8 = 1'b1; op8 = ro; a8 = ra; b8 = rb;
      @(negedge clk);
      start8 = 1'b0;
      if (ro > MD_MTLO) chk("rsv_busy8", {63'd0, busy8}, 64'd0);
      for (int i = 0; i < 20 && sb8.size() != 0; i++) @(negedge clk);
      if (sb8.size() != 0) begin
        chk("rnd_timeout", 64'(sb8.size()), 64'd0);
        sb8.delete();
      end
      repeat (2) @(negedge clk);
    end

    chk("sb_empty", 64'(sb.size() + sb8.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
